peek_resp_uart_tx: RTL



---
 rtl/peek_link_pkg.sv | 14 +
 rtl/uart_baud_gen.sv | 29 ++
 rtl/peek_resp_uart_tx.sv | 109 ++++++++++
 3 files changed

// File: rtl/peek_link_pkg.sv
// Shared types and constants for the peek debug link (command and response paths).
package peek_link_pkg;

  localparam int PEEK_FRAME_BYTES = 5;
  localparam int UART_DATA_BITS   = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] data;
  } peek_resp_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts clk cycles while enabled and flags the last cycle of each bit.
module uart_baud_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_reg;

  // Held at zero while disabled so every frame starts on a fresh bit period.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt_reg <= '0;
    end else if (cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign tick = en && (cnt_reg == LAST);

endmodule

// File: rtl/peek_resp_uart_tx.sv
// Serialises a peek response {id, data} onto the UART tx line as a 5-byte 8N1 frame, LSB first.
module peek_resp_uart_tx
  import peek_link_pkg::*;
#(
  parameter int CLK_DIV     = 16,
  parameter int FRAME_BYTES = PEEK_FRAME_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        resp_valid,
  output logic        resp_ready,
  input  logic [7:0]  resp_id,
  input  logic [31:0] resp_data,
  output logic        tx,
  output logic        busy,
  output logic        clk_tx_tick
);

  localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0] LAST_BYTE = 3'(FRAME_BYTES - 1);

  tx_state_t  state_reg, state_next;
  peek_resp_t shift_reg;
  peek_resp_t captured;
  logic [2:0] bit_cnt_reg;
  logic [2:0] byte_cnt_reg;
  logic       ready_en_reg;
  logic       baud_en;
  logic       tick;
  logic       handshake;

  assign captured  = '{id: resp_id, data: resp_data};
  assign baud_en   = (state_reg != IDLE);
  assign handshake = resp_valid && resp_ready;

  uart_baud_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .en  (baud_en),
    .tick(tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:  if (handshake) state_next = START;
      START: if (tick) state_next = DATA;
      DATA:  if (tick && bit_cnt_reg == LAST_BIT) state_next = STOP;
      STOP:  if (tick) state_next = (byte_cnt_reg == LAST_BYTE) ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end

  // The buffer shifts right once per data bit, so bit 0 always holds the bit on the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      byte_cnt_reg <= '0;
      ready_en_reg <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      unique case (state_reg)
        IDLE: begin
          if (handshake) begin
            shift_reg    <= captured;
            bit_cnt_reg  <= '0;
            byte_cnt_reg <= '0;
          end
        end
        DATA: begin
          if (tick) begin
            shift_reg   <= shift_reg >> 1;
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
          end
        end
        STOP: begin
          if (tick && byte_cnt_reg != LAST_BYTE) begin
            byte_cnt_reg <= byte_cnt_reg + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tx          = 1'b1;
    busy        = (state_reg != IDLE);
    resp_ready  = (state_reg == IDLE) && ready_en_reg;
    clk_tx_tick = tick;
    unique case (state_reg)
      START:   tx = 1'b0;
      DATA:    tx = shift_reg[0];
      default: tx = 1'b1;
    endcase
  end

endmodule
